// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared types and active-low segment codes for the
//                four-digit seven-segment scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Slot phase: anodes off (ghosting guard) or driving the current digit
    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    typedef logic [1:0] digit_idx_t;

    // Segment codes are {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    // Hex glyph table, index 15 leftmost
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [3:0] ANODE_OFF = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/module_hex_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : module_hex_to_7seg
//  Description : Combinational 4-bit value to active-low seven-segment code
//                ({g,f,e,d,c,b,a}).
//  Revision    : 1.0 - initial release
// ============================================================================
module module_hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[value];

endmodule
`default_nettype wire

// File: rtl/module_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : module_display_scan
//  Description : Time-multiplexed four-digit common-anode seven-segment driver
//                for the Hamming(7,4) correction result. Captures the data
//                nibble and syndrome on load_i and scans:
//                  digit0 = hex data, digit1 = syndrome, digit2 = 'E' on
//                  error, digit3 = blank.
//                Optional macro DISPLAY_BLINK_EN blinks the digit2 'E'.
//  Revision    : 1.0 - initial release
// ============================================================================
module module_display_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 27000,
    parameter int BLANK_CYC   = 16,
    parameter int BLINK_SLOTS = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dato_i,
    input  logic [2:0] sindrome_i,
    input  logic       load_i,
    output logic [3:0] anodo_o,
    output logic [6:0] siete_seg_o,
    output logic       dp_o,
    output logic       error_o
);

    localparam int                 PRESC_W      = $clog2(REFRESH_DIV);
    localparam logic [PRESC_W-1:0] C_PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [PRESC_W-1:0] C_BLANK_END  = PRESC_W'(BLANK_CYC);

    // Reject parameter sets that would break the slot timing
    if ((REFRESH_DIV < 4) || (BLANK_CYC >= REFRESH_DIV) || (BLANK_CYC < 0) ||
        (BLINK_SLOTS < 1)) begin : g_param_check
        $error("module_display_scan: illegal parameter combination");
    end

    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] w_presc_next;
    logic               w_presc_wrap;
    digit_idx_t         r_digit;
    scan_state_t        r_state;
    scan_state_t        w_state_next;
    logic [3:0]         r_dato;
    logic [2:0]         r_sind;
    logic [3:0]         w_digit_val;
    logic [6:0]         w_seg_hex;
    logic [6:0]         w_seg_code;
    logic               w_e_on;

    assign w_presc_wrap = (r_presc == C_PRESC_LAST);
    assign w_presc_next = w_presc_wrap ? '0 : r_presc + 1'b1;

    // Free-running prescaler and digit index; the digit advances on slot wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_digit <= '0;
        end else begin
            r_presc <= w_presc_next;
            if (w_presc_wrap) begin
                r_digit <= r_digit + 1'b1;
            end
        end
    end

    // Slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next slot state: kept aligned with the prescaler value it describes
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BLANK: begin
                if (w_presc_next == C_BLANK_END) begin
                    w_state_next = DRIVE;
                end
            end
            DRIVE: begin
                // With no guard interval the slot never leaves DRIVE
                if (w_presc_wrap && (BLANK_CYC != 0)) begin
                    w_state_next = BLANK;
                end
            end
            default: w_state_next = BLANK;
        endcase
    end

    // Holding registers for the corrected nibble and syndrome, plus error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dato  <= '0;
            r_sind  <= '0;
            error_o <= 1'b0;
        end else if (load_i) begin
            r_dato  <= dato_i;
            r_sind  <= sindrome_i;
            error_o <= (sindrome_i != 3'd0);
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int               BLINK_W      = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
    localparam logic [BLINK_W-1:0] C_BLINK_LAST = BLINK_W'(BLINK_SLOTS - 1);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_off;

    // Blink phase advances once per complete scan so every digit2 visit in a
    // half-period looks the same; phase starts "on" after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (w_presc_wrap && (r_digit == 2'd3)) begin
            if (r_blink_cnt == C_BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_e_on = ~r_blink_off;
`else
    assign w_e_on = 1'b1;
`endif

    // Value fed to the single hex encoder: syndrome on digit1, data otherwise
    always_comb begin
        w_digit_val = r_dato;
        if (r_digit == 2'd1) begin
            w_digit_val = {1'b0, r_sind};
        end
    end

    module_hex_to_7seg u_hex_to_7seg (
        .value (w_digit_val),
        .seg   (w_seg_hex)
    );

    // Glyph for the current digit, including the error marker and blank digit
    always_comb begin
        w_seg_code = w_seg_hex;
        case (r_digit)
            2'd2:    w_seg_code = ((r_sind != 3'd0) && w_e_on) ? SEG_E : SEG_BLANK;
            2'd3:    w_seg_code = SEG_BLANK;
            default: w_seg_code = w_seg_hex;
        endcase
    end

    // Registered display outputs: one cycle behind the prescaler/state
    always_ff @(posedge clk) begin
        if (rst) begin
            anodo_o     <= ANODE_OFF;
            siete_seg_o <= SEG_BLANK;
            dp_o        <= 1'b1;
        end else begin
            dp_o <= 1'b1;
            if (r_state == DRIVE) begin
                anodo_o     <= ~(4'b0001 << r_digit);
                siete_seg_o <= w_seg_code;
            end else begin
                anodo_o     <= ANODE_OFF;
                siete_seg_o <= SEG_BLANK;
            end
        end
    end

endmodule
`default_nettype wire
